// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: per-register countdown to forwardability.
// Optional variable-latency PENDING state under SCOREBOARD_VARLAT_EN.
module reg_scoreboard #(
  parameter int NREG    = 8,
  parameter int AW      = $clog2(NREG),
  parameter int CW      = 3,
  parameter int NRD     = 2,
  parameter int LAT_ALU = 2,
  parameter int LAT_MEM = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_decode,
  input  logic              issue_valid,
  input  logic              issue_mem,
  input  logic              issue_var,
  input  logic [AW-1:0]     issue_adr,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_adr,
  input  logic [NRD*AW-1:0] rd_adr,
  output logic [NRD-1:0]    rd_busy,
  output logic [NRD*CW-1:0] rd_cnt,
  output logic [NREG*CW-1:0] reg_cnt,
  output logic              issue_stall
);

  if (LAT_ALU > 2**CW-1 || LAT_MEM > 2**CW-1) begin : g_lat_chk
    $error("reg_scoreboard: latency does not fit in CW bits");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_PEND
  } st_e;

  localparam logic [CW-1:0] LA = CW'(LAT_ALU);
  localparam logic [CW-1:0] LM = CW'(LAT_MEM);

  st_e           st_q  [NREG];
  st_e           st_d  [NREG];
  logic [CW-1:0] cnt_q [NREG];
  logic [CW-1:0] cnt_d [NREG];

  logic          var_op;
  logic          wb_en;
  logic          issue_eff;
  logic [CW-1:0] lat;

`ifdef SCOREBOARD_VARLAT_EN
  assign var_op      = issue_var;
  assign wb_en       = wb_valid;
  assign issue_stall = issue_valid & (st_q[issue_adr] == S_PEND);
`else
  logic unused_varlat;
  assign unused_varlat = issue_var ^ wb_valid;
  assign var_op        = 1'b0;
  assign wb_en         = 1'b0;
  assign issue_stall   = 1'b0;
`endif

  assign issue_eff = issue_valid & ~flush_decode & ~issue_stall;
  assign lat       = issue_mem ? LM : LA;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        st_q[r]  <= S_IDLE;
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        st_q[r]  <= st_d[r];
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  // Load takes max(decremented, latency) so a younger fast writer
  // never shortens an older slow one.
  always_comb begin
    logic [CW-1:0] nc;
    logic          hit;
    logic          wb_hit;
    nc     = '0;
    hit    = 1'b0;
    wb_hit = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      hit    = issue_eff & (issue_adr == AW'(r));
      wb_hit = wb_en & (wb_adr == AW'(r));
      nc     = (cnt_q[r] != '0) ? cnt_q[r] - 1'b1 : '0;
      cnt_d[r] = nc;
      st_d[r]  = (nc != '0) ? S_COUNT : S_IDLE;
      unique case (1'b1)
        (st_q[r] == S_PEND): begin
          cnt_d[r] = '0;
          st_d[r]  = wb_hit ? S_IDLE : S_PEND;
        end
        (hit && var_op): begin
          cnt_d[r] = '0;
          st_d[r]  = S_PEND;
        end
        hit: begin
          if (lat > nc) nc = lat;
          cnt_d[r] = nc;
          st_d[r]  = (nc != '0) ? S_COUNT : S_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    logic [AW-1:0] a;
    a       = '0;
    reg_cnt = '0;
    rd_cnt  = '0;
    rd_busy = '0;
    for (int r = 0; r < NREG; r++) begin
      reg_cnt[r*CW +: CW] = cnt_q[r];
    end
    for (int k = 0; k < NRD; k++) begin
      a = rd_adr[k*AW +: AW];
      rd_cnt[k*CW +: CW] = cnt_q[a];
      rd_busy[k]         = (st_q[a] != S_IDLE);
    end
  end

endmodule
